dram_addr_demux: RTL
====================

# dram_addr_demux

Recovers full DRAM word addresses from a row/column-multiplexed address bus, the receiving end of the quad 2-to-1 address multiplexers that drive the DRAM array. It synchronises `_RAS`/`_CAS`/`_WE` into the system clock and latches the row on the `_RAS` fall and the column on each `_CAS` fall. It emits one buffered access record per column strobe, with fast-page-mode and CAS-before-RAS refresh detection. It sits beside the chip-RAM model as a bus monitor and front end for the memory model.

## Interface
- `ROW_BITS`, default 9: width of the multiplexed address bus; the output address is `2*ROW_BITS` bits.
- `SYNC_STAGES`, default 2, minimum 2: synchroniser depth for strobes and address.
- `CLK`  in  1: system clock; all state updates on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `MA`  in  ROW_BITS: multiplexed address bus, asynchronous to `CLK`.
- `_RAS`  in  1: row strobe, active low, asynchronous.
- `_CAS`  in  1: column strobe, active low, asynchronous.
- `_WE`  in  1: write enable, active low, asynchronous.
- `ADDR`  out  2*ROW_BITS: {row, column} of the buffered access.
- `WRITE`  out  1: 1 when `_WE` was low at the column strobe.
- `VALID`  out  1: buffered access present.
- `READY`  in  1: consumer accepts the record on a cycle where `VALID & READY`.
- `REFRESH`  out  1: one-cycle pulse per CBR refresh.
- `OVERRUN`  out  1: one-cycle pulse when an access is dropped.

## Operation
- `_RAS`, `_CAS`, `_WE` and `MA` pass through identical `SYNC_STAGES` flop chains, so the address stays aligned with the strobes.
- Edge detection runs on the synchronised strobes, using one extra history flop each.
- States:
  - IDLE: RAS high.
  - ROW_OPEN: row latched, CAS high.
  - COLUMN: CAS low inside RAS.
  - REFRESH: RAS low, entered with CAS already low.
- IDLE → ROW_OPEN on RAS fall with CAS high; the synced `MA` is latched as the row.
- IDLE → REFRESH on RAS fall with CAS low, or with a CAS fall in the same sample. `REFRESH` pulses once.
- ROW_OPEN → COLUMN on CAS fall. The column is `{row, synced MA}`, with `WRITE = ~synced _WE`, and the record is offered to the buffer.
- COLUMN → ROW_OPEN on CAS rise (fast page mode). Each further CAS fall produces a new record with the same row.
- Any state → IDLE on a synced RAS rise. A partial access without a CAS fall produces nothing.
- CAS falls in IDLE with RAS high are ignored, with no record and no pulse.
- Output buffer is one entry:
  - Loads when empty, or when `VALID & READY` in the same cycle as the offer (no overrun).
  - If full and not being read, the new record is discarded, the old one is kept, and `OVERRUN` pulses.
  - `VALID` clears on `READY` when no new record arrives.
- Row and column values are passed through unmodified; there is no arithmetic.

## Timing
- Reset values:
  - `ADDR` = 0, `WRITE` = 0, `VALID` = 0, `REFRESH` = 0, `OVERRUN` = 0.
  - State IDLE.
  - All strobe synchroniser and history flops preset to 1 (inactive), so releasing reset never creates a false edge.
- Latency: a `_CAS` fall seen at rising edge n gives `VALID` = 1 after edge n+SYNC_STAGES+1. `REFRESH` has the same latency from the RAS fall.
- `_RAS` and `_CAS` pulse widths and `MA` setup/hold around the strobes must each be at least SYNC_STAGES+1 clocks. Shorter pulses give undefined results.
- `RESET` asserted mid-access drops the held record and returns to IDLE immediately. After release, the first new RAS fall starts a fresh access.
- Pulses on `REFRESH` and `OVERRUN` last exactly one cycle and never stretch.

## Structure
- Shared package `amigo_dram_pkg` holds:
  - the state enum (IDLE, ROW_OPEN, COLUMN, REFRESH);
  - `DEFAULT_ROW_BITS` = 9;
  - the record typedef {addr, write}.
- Sub-module `sync_chain`: a parameterised-width, parameterised-depth flop chain with a reset-preset value. It is instantiated for the strobes (preset 1) and for `MA` (preset 0).

## Test plan
- Single read: RAS fall with `MA` = 0x0A5, CAS fall with `MA` = 0x13C, `_WE` high → one record with `ADDR` = 0x14B3C, `WRITE` = 0, `VALID` at CAS+3 clocks.
- Page mode: row 0x001, then columns 0x010, 0x011, 0x012 with `_WE` low, `READY` = 1 → three records 0x00210, 0x00211, 0x00212, all with `WRITE` = 1.
- CBR refresh: CAS low, then RAS low → exactly one `REFRESH` pulse and no `VALID`.
- Overrun: `READY` = 0, two page-mode columns 0x020 and 0x021 → `ADDR` holds column 0x020 and `OVERRUN` pulses once. With `READY` high at the second offer instead, the record becomes column 0x021 with no pulse.
- Reset mid-access: assert `RESET` between the RAS fall and the CAS fall → all outputs 0. After release, the next full access yields exactly one correct record.

Source files
------------

// File: rtl/amigo_dram_pkg.sv
// Shared types and constants for the DRAM address demultiplexer.
package amigo_dram_pkg;

    localparam int unsigned DEFAULT_ROW_BITS = 9;

    // Access tracking state as seen through the synchronised strobes.
    typedef enum logic [1:0] {
        StIdle,
        StRowOpen,
        StColumn,
        StRefresh
    } dram_state_e;

    // One access record at the default bus width: {row, column} plus write flag.
    typedef struct packed {
        logic [2*DEFAULT_ROW_BITS-1:0] addr;
        logic                          write;
    } dram_rec_t;

endpackage

// File: rtl/sync_chain.sv
// Parameterised flop chain used to bring asynchronous signals into the clock domain.
module sync_chain #(
    parameter int unsigned      WIDTH  = 1,
    parameter int unsigned      DEPTH  = 2,
    parameter logic [WIDTH-1:0] PRESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the input through DEPTH stages; reset loads the preset into every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= PRESET;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/dram_addr_demux.sv
// Rebuilds {row, column} word addresses from a multiplexed DRAM address bus and
// hands them out through a one-entry buffer, flagging CBR refresh and overruns.
module dram_addr_demux
    import amigo_dram_pkg::*;
#(
    parameter int unsigned ROW_BITS    = DEFAULT_ROW_BITS,
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ROW_BITS-1:0]   MA,
    input  logic                  _RAS,
    input  logic                  _CAS,
    input  logic                  _WE,
    output logic [2*ROW_BITS-1:0] ADDR,
    output logic                  WRITE,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  REFRESH,
    output logic                  OVERRUN
);

    // Same layout as dram_rec_t, sized for this instance's bus width.
    typedef struct packed {
        logic [2*ROW_BITS-1:0] addr;
        logic                  write;
    } rec_t;

    logic [2:0]          strb_s;
    logic [ROW_BITS-1:0] ma_s;
    logic                ras_s, cas_s, we_s;
    logic                ras_h, cas_h;
    logic                ras_fall, ras_rise, cas_fall, cas_rise;

    dram_state_e         state_q, state_d;
    logic                row_load, offer, cbr;

    logic [ROW_BITS-1:0] row_q;
    logic                offer_q, cbr_q;
    rec_t                offer_rec_q;

    rec_t                buf_q;
    logic                valid_q, refresh_q, overrun_q;

    // Strobes and address use equal-depth chains so MA stays aligned with its strobe.
    sync_chain #(
        .WIDTH  (3),
        .DEPTH  (SYNC_STAGES),
        .PRESET (3'b111)
    ) u_strb_sync (
        .clk (CLK),
        .rst (RESET),
        .d   ({_RAS, _CAS, _WE}),
        .q   (strb_s)
    );

    sync_chain #(
        .WIDTH  (ROW_BITS),
        .DEPTH  (SYNC_STAGES),
        .PRESET ('0)
    ) u_ma_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (MA),
        .q   (ma_s)
    );

    assign ras_s = strb_s[2];
    assign cas_s = strb_s[1];
    assign we_s  = strb_s[0];

    // History flops for edge detection; preset inactive so reset release makes no edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ras_h <= 1'b1;
            cas_h <= 1'b1;
        end else begin
            ras_h <= ras_s;
            cas_h <= cas_s;
        end
    end

    assign ras_fall = ras_h & ~ras_s;
    assign ras_rise = ~ras_h & ras_s;
    assign cas_fall = cas_h & ~cas_s;
    assign cas_rise = ~cas_h & cas_s;

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a RAS rise closes any access.
    always_comb begin
        state_d = state_q;
        if (ras_rise) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (ras_fall) state_d = cas_s ? StRowOpen : StRefresh;
                StRowOpen: if (cas_fall) state_d = StColumn;
                StColumn:  if (cas_rise) state_d = StRowOpen;
                StRefresh: state_d = StRefresh;
                default:   state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: row capture, column offer, refresh detect (CAS already low at RAS fall).
    always_comb begin
        row_load = 1'b0;
        offer    = 1'b0;
        cbr      = 1'b0;
        if (!ras_rise) begin
            case (state_q)
                StIdle: begin
                    if (ras_fall) begin
                        row_load = cas_s;
                        cbr      = ~cas_s;
                    end
                end
                StRowOpen: offer = cas_fall;
                default: ;
            endcase
        end
    end

    // Latch the row and stage the offered record one cycle ahead of the buffer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_q       <= '0;
            offer_q     <= 1'b0;
            cbr_q       <= 1'b0;
            offer_rec_q <= '0;
        end else begin
            if (row_load) row_q <= ma_s;
            offer_q <= offer;
            cbr_q   <= cbr;
            if (offer) begin
                offer_rec_q <= '{addr: {row_q, ma_s}, write: ~we_s};
            end
        end
    end

    // One-entry output buffer; a full, unread buffer keeps its record and flags overrun.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            buf_q     <= '0;
            valid_q   <= 1'b0;
            refresh_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            refresh_q <= cbr_q;
            overrun_q <= 1'b0;
            if (offer_q) begin
                if (!valid_q || READY) begin
                    buf_q   <= offer_rec_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ADDR    = buf_q.addr;
    assign WRITE   = buf_q.write;
    assign VALID   = valid_q;
    assign REFRESH = refresh_q;
    assign OVERRUN = overrun_q;

endmodule
